// File: rtl/led_matrix_scan.sv
// 8x8 LED matrix row scanner with a double-buffered frame.
// Frames swap only at the end of row 7 so a displayed image never tears.
module led_matrix_scan #(
  parameter int unsigned DWELL  = 1000,
  parameter int unsigned BLANK  = 50,
  parameter bit          ROW_ON = 1'b1,
  parameter bit          COL_ON = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] frame_in,
  input  logic        frame_load,
  output logic [15:0] out,
  output logic        pending,
  output logic        frame_done
);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] BLANK_LAST = (BLANK == 0) ? 16'd0 : 16'(BLANK - 1);
  localparam logic [15:0] ALL_OFF    = {{8{~ROW_ON}}, {8{~COL_ON}}};

  state_t      state, state_nxt;
  logic [2:0]  row, row_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [63:0] shadow, active, active_nxt;
  logic        pending_nxt;

  function automatic logic [15:0] drive_pattern(input logic show, input logic [2:0] r,
                                                input logic [63:0] frame);
    logic [7:0] row_bits;
    logic [7:0] col_bits;
    row_bits = {8{~ROW_ON}};
    col_bits = {8{~COL_ON}};
    if (show) begin
      row_bits[r] = ROW_ON;
      for (int c = 0; c < 8; c++) begin
        if (frame[{r, 3'(c)}]) col_bits[3'(c)] = COL_ON;
      end
    end
    return {row_bits, col_bits};
  endfunction

  // With BLANK=0 the BLANK state is only ever the single post-reset cycle.
  always_comb begin
    state_nxt  = state;
    row_nxt    = row;
    cnt_nxt    = cnt + 16'd1;
    frame_done = 1'b0;
    case (state)
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = S_SHOW;
          cnt_nxt   = 16'd0;
        end
      end
      S_SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_nxt    = 16'd0;
          row_nxt    = row + 3'd1;
          state_nxt  = (BLANK == 0) ? S_SHOW : S_BLANK;
          frame_done = (row == 3'd7);
        end
      end
      default: state_nxt = S_BLANK;
    endcase

    active_nxt = (frame_done && pending) ? shadow : active;

    if (frame_load)      pending_nxt = 1'b1;
    else if (frame_done) pending_nxt = 1'b0;
    else                 pending_nxt = pending;
  end

  // out is registered from next-state values so it always matches the scan position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_BLANK;
      row     <= 3'd0;
      cnt     <= 16'd0;
      shadow  <= 64'd0;
      active  <= 64'd0;
      pending <= 1'b0;
      out     <= ALL_OFF;
    end else begin
      state   <= state_nxt;
      row     <= row_nxt;
      cnt     <= cnt_nxt;
      active  <= active_nxt;
      pending <= pending_nxt;
      if (frame_load) shadow <= frame_in;
      out     <= drive_pattern(state_nxt == S_SHOW, row_nxt, active_nxt);
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: scenario tasks plus a randomized run against a
// time-position reference model of the scan and buffer rules.
module tb_led_matrix_scan;

  localparam int B  = 1;
  localparam int D  = 4;
  localparam int RP = B + D;
  localparam int P  = 8 * RP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] frame_in = 64'd0;
  logic        frame_load = 1'b0;
  logic [15:0] out;
  logic        pending, frame_done;

  logic [63:0] frame_in2 = 64'd0;
  logic        frame_load2 = 1'b0;
  logic [15:0] out2;
  logic        pending2, frame_done2;

  int errors = 0;
  int checks = 0;

  int          m_t;
  logic [63:0] m_shadow, m_active;
  logic        m_pending;

  always #5 clk = ~clk;

  led_matrix_scan #(.DWELL(D), .BLANK(B), .ROW_ON(1'b1), .COL_ON(1'b0)) dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_load(frame_load),
    .out(out), .pending(pending), .frame_done(frame_done)
  );

  led_matrix_scan #(.DWELL(1), .BLANK(0), .ROW_ON(1'b1), .COL_ON(1'b0)) dut2 (
    .clk(clk), .rst(rst), .frame_in(frame_in2), .frame_load(frame_load2),
    .out(out2), .pending(pending2), .frame_done(frame_done2)
  );

  // Reference: position in frame is edges-since-reset modulo the frame period.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t       <= 0;
      m_shadow  <= 64'd0;
      m_active  <= 64'd0;
      m_pending <= 1'b0;
    end else begin
      if ((m_t % P) == P - 1 && m_pending) m_active <= m_shadow;
      if (frame_load) m_shadow <= frame_in;
      if (frame_load) m_pending <= 1'b1;
      else if ((m_t % P) == P - 1) m_pending <= 1'b0;
      m_t <= m_t + 1;
    end
  end

  function automatic int pos();
    return m_t % P;
  endfunction

  function automatic logic [15:0] model_out();
    int p, r;
    logic [7:0] rb;
    p = m_t % P;
    r = p / RP;
    if ((p % RP) < B) return 16'h00FF;
    rb = 8'(1 << r);
    return {rb, ~m_active[8*r +: 8]};
  endfunction

  task automatic wait_pos(input int target);
    for (int i = 0; i <= P; i++) begin
      @(negedge clk);
      if (pos() == target) break;
    end
  endtask

  task automatic pulse_load(input logic [63:0] f);
    frame_in   = f;
    frame_load = 1'b1;
    @(negedge clk);
    frame_load = 1'b0;
  endtask

  task automatic test_reset();
    wait_pos(1);
    pulse_load({$urandom, $urandom});
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL rst_pre_pending: got %b expected 1", pending); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out !== 16'h00FF) begin errors++; $display("FAIL rst_out_async: got %h expected 00ff", out); end
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b expected 0", pending); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out !== 16'h00FF) begin errors++; $display("FAIL rst_first_blank: got %h expected 00ff", out); end
    @(negedge clk);
    checks++;
    if (out !== 16'h01FF) begin errors++; $display("FAIL rst_first_row0: got %h expected 01ff", out); end
    wait_pos(1);
    checks++;
    if (out !== 16'h01FF) begin errors++; $display("FAIL rst_shadow_discarded: got %h expected 01ff", out); end
  endtask

  task automatic test_diagonal();
    int p, r;
    logic [7:0] rb;
    logic [15:0] exp;
    pulse_load(64'h8040201008040201);
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL diag_pending_rise: got %b expected 1", pending); end
    for (int i = 0; i < P + 2; i++) begin
      checks++;
      if (frame_done !== (pos() == P - 1)) begin
        errors++; $display("FAIL diag_frame_done_timing: got %b expected %b at pos %0d", frame_done, pos() == P - 1, pos());
      end
      if (pos() == P - 1) break;
      @(negedge clk);
    end
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      p  = pos();
      r  = p / RP;
      rb = 8'(1 << r);
      exp = ((p % RP) < B) ? 16'h00FF : {rb, ~rb};
      checks++;
      if (out !== exp) begin errors++; $display("FAIL diag_out: got %h expected %h at pos %0d", out, exp, p); end
      if (i == 0) begin
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL diag_pending_fall: got %b expected 0", pending); end
      end
    end
  endtask

  task automatic test_no_tearing();
    int p, r;
    logic [7:0] rb;
    wait_pos(3 * RP + B);
    checks++;
    if (out !== 16'h08F7) begin errors++; $display("FAIL tear_row3_before: got %h expected 08f7", out); end
    pulse_load(64'hFFFFFFFFFFFFFFFF);
    for (int i = 0; i < P; i++) begin
      p  = pos();
      r  = p / RP;
      rb = 8'(1 << r);
      if ((p % RP) >= B) begin
        checks++;
        if (out !== {rb, ~rb}) begin errors++; $display("FAIL tear_old_rows: got %h expected %h at pos %0d", out, {rb, ~rb}, p); end
      end
      if (p == P - 1) begin
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL tear_pending_high: got %b expected 1", pending); end
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL tear_frame_done: got %b expected 1", frame_done); end
        break;
      end
      @(negedge clk);
    end
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      p  = pos();
      r  = p / RP;
      rb = 8'(1 << r);
      if (i == 0) begin
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL tear_pending_low: got %b expected 0", pending); end
      end
      if ((p % RP) >= B) begin
        checks++;
        if (out !== {rb, 8'h00}) begin errors++; $display("FAIL tear_new_rows: got %h expected %h at pos %0d", out, {rb, 8'h00}, p); end
      end
    end
  endtask

  task automatic test_last_wins();
    int p, r;
    logic [7:0] rb;
    logic [7:0] cb;
    wait_pos(2);
    pulse_load(64'h00000000000000FF);
    pulse_load(64'hFF00000000000000);
    wait_pos(P - 1);
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      p  = pos();
      r  = p / RP;
      rb = 8'(1 << r);
      cb = (r == 7) ? 8'h00 : 8'hFF;
      if ((p % RP) >= B) begin
        checks++;
        if (out !== {rb, cb}) begin errors++; $display("FAIL last_wins_out: got %h expected %h at pos %0d", out, {rb, cb}, p); end
      end
    end
  endtask

  task automatic test_coincident();
    int p, r;
    logic [7:0] rb;
    logic [63:0] x;
    x = {$urandom, $urandom};
    wait_pos(10);
    pulse_load(x);
    wait_pos(P - 1);
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL coinc_frame_done: got %b expected 1", frame_done); end
    pulse_load(64'hAAAAAAAAAAAAAAAA);
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL coinc_pending_stays: got %b expected 1", pending); end
    for (int i = 0; i < P; i++) begin
      if (i > 0) @(negedge clk);
      p  = pos();
      r  = p / RP;
      rb = 8'(1 << r);
      if ((p % RP) >= B) begin
        checks++;
        if (out !== {rb, ~x[8*r +: 8]}) begin
          errors++; $display("FAIL coinc_prev_shadow: got %h expected %h at pos %0d", out, {rb, ~x[8*r +: 8]}, p);
        end
      end
      if (p == P - 1) begin
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL coinc_second_swap: got %b expected 1", frame_done); end
      end
    end
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      p  = pos();
      r  = p / RP;
      rb = 8'(1 << r);
      if ((p % RP) >= B) begin
        checks++;
        if (out !== {rb, 8'h55}) begin errors++; $display("FAIL coinc_aa_frame: got %h expected %h at pos %0d", out, {rb, 8'h55}, p); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (out !== model_out()) begin errors++; $display("FAIL rand_out: got %h expected %h at t %0d", out, model_out(), m_t); end
      checks++;
      if (pending !== m_pending) begin errors++; $display("FAIL rand_pending: got %b expected %b at t %0d", pending, m_pending, m_t); end
      checks++;
      if (frame_done !== (pos() == P - 1)) begin
        errors++; $display("FAIL rand_frame_done: got %b expected %b at t %0d", frame_done, pos() == P - 1, m_t);
      end
      frame_load = ($urandom_range(0, 7) == 0);
      frame_in   = {$urandom, $urandom};
    end
    frame_load = 1'b0;
  endtask

  task automatic test_blank0();
    logic [63:0] f2;
    logic [7:0]  rb;
    logic [15:0] exp;
    logic        found;
    int k;
    f2 = {$urandom, $urandom};
    @(negedge clk);
    frame_in2   = f2;
    frame_load2 = 1'b1;
    @(negedge clk);
    frame_load2 = 1'b0;
    checks++;
    if (pending2 !== 1'b1) begin errors++; $display("FAIL blank0_pending: got %b expected 1", pending2); end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (frame_done2 === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL blank0_frame_done_seen: got 0 expected 1 within 10 cycles"); end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      k   = i % 8;
      rb  = 8'(1 << k);
      exp = {rb, ~f2[8*k +: 8]};
      checks++;
      if (out2 !== exp) begin errors++; $display("FAIL blank0_out: got %h expected %h at step %0d", out2, exp, i); end
      checks++;
      if (out2 === 16'h00FF) begin errors++; $display("FAIL blank0_never_off: got %h expected not 00ff", out2); end
      checks++;
      if (frame_done2 !== (k == 7)) begin errors++; $display("FAIL blank0_frame_done: got %b expected %b at step %0d", frame_done2, k == 7, i); end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_diagonal();
    test_no_tearing();
    test_last_wins();
    test_coincident();
    test_random();
    test_blank0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
